// File: rtl/float_decode_stage.sv
// Registered RV32F/RV32D floating-point decode stage: decodes OP-FP and R4 fused
// multiply-add words into FPU unit selects and micro-ops, behind a 2-entry skid queue.
module float_decode_stage #(
  parameter bit          ENABLE_DOUBLE = 1'b0,
  parameter bit          ENABLE_FMA    = 1'b1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 instr_valid_i,
  input  logic [31:0]          instr_i,
  output logic                 instr_ready_o,
  input  logic [2:0]           frm_i,
  output logic                 issue_valid_o,
  input  logic                 issue_ready_i,
  output logic [3:1][4:0]      reg_src_o,
  output logic [4:0]           reg_dest_o,
  output logic                 is_double_o,
  output logic [2:0]           rm_o,
  output logic [5:0]           unit_valid_o,
  output logic [4:0]           op_o,
  output logic                 is_signed_o,
  output logic                 flag_o,
  output logic                 exception_generated_o,
  output logic [CNT_WIDTH-1:0] illegal_count_o
);

  localparam logic [6:0] OPC_OP_FP = 7'b1010011;

  localparam logic [5:0] U_ADD = 6'b000001;
  localparam logic [5:0] U_MUL = 6'b000010;
  localparam logic [5:0] U_CMP = 6'b000100;
  localparam logic [5:0] U_MIS = 6'b001000;
  localparam logic [5:0] U_CVT = 6'b010000;
  localparam logic [5:0] U_FMA = 6'b100000;

  localparam logic [4:0] OP_FADD   = 5'd1;
  localparam logic [4:0] OP_FSUB   = 5'd2;
  localparam logic [4:0] OP_FMUL   = 5'd3;
  localparam logic [4:0] OP_FMADD  = 5'd4;
  localparam logic [4:0] OP_FSGNJ  = 5'd8;
  localparam logic [4:0] OP_FSGNJN = 5'd9;
  localparam logic [4:0] OP_FSGNJX = 5'd10;
  localparam logic [4:0] OP_FMIN   = 5'd11;
  localparam logic [4:0] OP_FMAX   = 5'd12;
  localparam logic [4:0] OP_FEQ    = 5'd13;
  localparam logic [4:0] OP_FLT    = 5'd14;
  localparam logic [4:0] OP_FLE    = 5'd15;
  localparam logic [4:0] OP_FCLASS = 5'd16;
  localparam logic [4:0] OP_FMV_XW = 5'd17;
  localparam logic [4:0] OP_FMV_WX = 5'd18;
  localparam logic [4:0] OP_F2I    = 5'd19;
  localparam logic [4:0] OP_I2F    = 5'd20;
  localparam logic [4:0] OP_F2F    = 5'd21;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       is_double;
    logic [2:0] rm;
    logic [5:0] unit;
    logic [4:0] op;
    logic       is_signed;
    logic       flag;
    logic       exc;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] funct5;
  logic [1:0] fmt;
  logic [4:0] rs2;
  logic       fmt_ok;
  logic       is_r4;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct5 = instr_i[31:27];
  assign fmt    = instr_i[26:25];
  assign rs2    = instr_i[24:20];
  assign fmt_ok = (fmt == 2'b00) || ((fmt == 2'b01) && ENABLE_DOUBLE);
  // The four fused multiply-add opcodes differ only in bits [3:2].
  assign is_r4  = (opcode[6:4] == 3'b100) && (opcode[1:0] == 2'b11);

  entry_t     dec;
  logic       legal;
  logic       use_rm;
  logic [2:0] rm_res;

  assign rm_res = (funct3 == 3'b111) ? frm_i : funct3;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec     = '0;
    legal   = 1'b0;
    use_rm  = 1'b0;
    dec.rs1 = instr_i[19:15];
    dec.rs2 = rs2;
    dec.rd  = instr_i[11:7];

    if (opcode == OPC_OP_FP) begin
      legal = fmt_ok;
      case (funct5)
        5'b00000: begin dec.unit = U_ADD; dec.op = OP_FADD; use_rm = 1'b1; end
        5'b00001: begin dec.unit = U_ADD; dec.op = OP_FSUB; use_rm = 1'b1; end
        5'b00010: begin dec.unit = U_MUL; dec.op = OP_FMUL; use_rm = 1'b1; end
        5'b00100: begin
          dec.unit = U_MIS;
          case (funct3)
            3'b000:  dec.op = OP_FSGNJ;
            3'b001:  dec.op = OP_FSGNJN;
            3'b010:  dec.op = OP_FSGNJX;
            default: legal = 1'b0;
          endcase
        end
        5'b00101: begin
          dec.unit = U_CMP;
          case (funct3)
            3'b000:  dec.op = OP_FMIN;
            3'b001:  dec.op = OP_FMAX;
            default: legal = 1'b0;
          endcase
        end
        5'b10100: begin
          dec.unit = U_CMP;
          dec.flag = 1'b1;
          case (funct3)
            3'b010:  dec.op = OP_FEQ;
            3'b001:  dec.op = OP_FLT;
            3'b000:  dec.op = OP_FLE;
            default: legal = 1'b0;
          endcase
        end
        5'b11100: begin
          dec.unit = U_MIS;
          if (rs2 == 5'd0 && funct3 == 3'b001)                     dec.op = OP_FCLASS;
          else if (rs2 == 5'd0 && funct3 == 3'b000 && fmt == 2'b00) dec.op = OP_FMV_XW;
          else                                                      legal  = 1'b0;
        end
        5'b11110: begin
          dec.unit = U_MIS;
          dec.op   = OP_FMV_WX;
          if (!(rs2 == 5'd0 && funct3 == 3'b000 && fmt == 2'b00)) legal = 1'b0;
        end
        5'b11000, 5'b11010: begin
          dec.unit      = U_CVT;
          dec.op        = funct5[1] ? OP_I2F : OP_F2I;
          dec.is_signed = !rs2[0];
          use_rm        = 1'b1;
          if (rs2[4:1] != 4'd0) legal = 1'b0;
        end
        5'b01000: begin
          dec.unit = U_CVT;
          dec.op   = OP_F2F;
          use_rm   = 1'b1;
          if (!(ENABLE_DOUBLE && ((rs2 == 5'd1 && fmt == 2'b00) ||
                                  (rs2 == 5'd0 && fmt == 2'b01)))) legal = 1'b0;
        end
        default: legal = 1'b0;
      endcase
    end else if (ENABLE_FMA && is_r4) begin
      legal    = fmt_ok;
      dec.rs3  = instr_i[31:27];
      dec.unit = U_FMA;
      dec.op   = OP_FMADD + {3'b000, opcode[3:2]};
      use_rm   = 1'b1;
    end

    // Reserved rounding modes are only reachable through the dynamic frm path
    // or an explicit 101/110 funct3, and either way the instruction traps.
    if (use_rm) begin
      dec.rm = rm_res;
      if (rm_res[2] && (rm_res[1] || rm_res[0])) legal = 1'b0;
    end
    dec.is_double = (fmt == 2'b01);

    if (!legal) begin
      dec.unit      = '0;
      dec.op        = '0;
      dec.is_signed = 1'b0;
      dec.flag      = 1'b0;
      dec.rm        = '0;
      dec.is_double = 1'b0;
      dec.exc       = 1'b1;
    end
  end

  logic [1:0]           count_q, count_d;
  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 pop;

  assign instr_ready_o = (count_q != 2'd2);
  assign issue_valid_o = (count_q != 2'd0);
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;
  assign pop           = issue_valid_o && issue_ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = dec;
          else                 tail_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Accept implies count<2 and pop implies count>0, so count is 1 here.
        2'b11:   head_d = dec;
        default: ;
      endcase
    end

    if (accept && dec.exc && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      count_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: queue payload storage is deliberately not reset; outputs are masked by
  // issue_valid_o, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  entry_t out;
  assign out = issue_valid_o ? head_q : '0;

  assign reg_src_o[1]          = out.rs1;
  assign reg_src_o[2]          = out.rs2;
  assign reg_src_o[3]          = out.rs3;
  assign reg_dest_o            = out.rd;
  assign is_double_o           = out.is_double;
  assign rm_o                  = out.rm;
  assign unit_valid_o          = out.unit;
  assign op_o                  = out.op;
  assign is_signed_o           = out.is_signed;
  assign flag_o                = out.flag;
  assign exception_generated_o = out.exc;
  assign illegal_count_o       = cnt_q;

endmodule

// File: tb/tb_float_decode_stage.sv
// Scoreboard bench for float_decode_stage: a full-featured instance and a
// single-only, no-FMA, 2-bit-counter instance driven by the same stimulus.
module tb_float_decode_stage;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       dbl;
    logic [2:0] rm;
    logic [5:0] unit;
    logic [4:0] op;
    logic       sgn;
    logic       flag;
    logic       exc;
  } resp_t;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  frm;
    resp_t       exp_a;
    resp_t       exp_b;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [2:0]  frm_i;
  logic        issue_ready_i;

  logic            ready_a, valid_a, dbl_a, sgn_a, flag_a, exc_a;
  logic [3:1][4:0] src_a;
  logic [4:0]      dest_a, op_a;
  logic [2:0]      rm_a;
  logic [5:0]      unit_a;
  logic [15:0]     count_a;

  logic            ready_b, valid_b, dbl_b, sgn_b, flag_b, exc_b;
  logic [3:1][4:0] src_b;
  logic [4:0]      dest_b, op_b;
  logic [2:0]      rm_b;
  logic [5:0]      unit_b;
  logic [1:0]      count_b;

  resp_t resp_a, resp_b;
  assign resp_a = {src_a[1], src_a[2], src_a[3], dest_a, dbl_a, rm_a, unit_a, op_a, sgn_a, flag_a, exc_a};
  assign resp_b = {src_b[1], src_b[2], src_b[3], dest_b, dbl_b, rm_b, unit_b, op_b, sgn_b, flag_b, exc_b};

  always #5 clk_i = ~clk_i;

  float_decode_stage #(.ENABLE_DOUBLE(1'b1), .ENABLE_FMA(1'b1), .CNT_WIDTH(16)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(ready_a),
    .frm_i(frm_i), .issue_valid_o(valid_a), .issue_ready_i(issue_ready_i),
    .reg_src_o(src_a), .reg_dest_o(dest_a), .is_double_o(dbl_a), .rm_o(rm_a),
    .unit_valid_o(unit_a), .op_o(op_a), .is_signed_o(sgn_a), .flag_o(flag_a),
    .exception_generated_o(exc_a), .illegal_count_o(count_a)
  );

  float_decode_stage #(.ENABLE_DOUBLE(1'b0), .ENABLE_FMA(1'b0), .CNT_WIDTH(2)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(ready_b),
    .frm_i(frm_i), .issue_valid_o(valid_b), .issue_ready_i(issue_ready_i),
    .reg_src_o(src_b), .reg_dest_o(dest_b), .is_double_o(dbl_b), .rm_o(rm_b),
    .unit_valid_o(unit_b), .op_o(op_b), .is_signed_o(sgn_b), .flag_o(flag_b),
    .exception_generated_o(exc_b), .illegal_count_o(count_b)
  );

  int    compared   = 0;
  int    mismatched = 0;
  int    exp_cnt_a  = 0;
  int    exp_cnt_b  = 0;
  int    stall_cycles = 0;
  resp_t q_a[$];
  resp_t q_b[$];
  vec_t  vecs[$];
  resp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t ok(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                               input logic [4:0] rd, input logic dbl, input logic [2:0] rm,
                               input logic [5:0] unit, input logic [4:0] op, input logic sgn,
                               input logic flag);
    resp_t r;
    r = '{rs1: rs1, rs2: rs2, rs3: rs3, rd: rd, dbl: dbl, rm: rm, unit: unit, op: op,
          sgn: sgn, flag: flag, exc: 1'b0};
    return r;
  endfunction

  function automatic resp_t ill(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    resp_t r;
    r     = '0;
    r.rs1 = rs1;
    r.rs2 = rs2;
    r.rd  = rd;
    r.exc = 1'b1;
    return r;
  endfunction

  // b_ill marks words that only the single-only, no-FMA instance rejects.
  function automatic void add(input logic [31:0] word, input logic [2:0] frm,
                              input resp_t exp_a, input bit b_ill);
    vec_t v;
    v.word  = word;
    v.frm   = frm;
    v.exp_a = exp_a;
    v.exp_b = (b_ill || exp_a.exc) ? ill(exp_a.rs1, exp_a.rs2, exp_a.rd) : exp_a;
    vecs.push_back(v);
  endfunction

  task automatic push(input int idx);
    int w;
    w             = 0;
    instr_valid_i = 1'b1;
    instr_i       = vecs[idx].word;
    frm_i         = vecs[idx].frm;
    @(negedge clk_i);
    while (!ready_a && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    if (!ready_a) begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout: vector %0d never accepted", idx);
      instr_valid_i = 1'b0;
      return;
    end
    stall_cycles += w;
    @(posedge clk_i);
    q_a.push_back(vecs[idx].exp_a);
    q_b.push_back(vecs[idx].exp_b);
    if (vecs[idx].exp_a.exc) exp_cnt_a++;
    if (vecs[idx].exp_b.exc && exp_cnt_b != 3) exp_cnt_b++;
    #1;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && valid_a && issue_ready_i) begin
      if (q_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a_unexpected_issue: got 0x%0h expected no entry", resp_a);
      end else begin
        mon_e = q_a.pop_front();
        check("a_issue", 64'(resp_a), 64'(mon_e));
      end
    end
    if (!rst_i && valid_b && issue_ready_i) begin
      if (q_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b_unexpected_issue: got 0x%0h expected no entry", resp_b);
      end else begin
        mon_e = q_b.pop_front();
        check("b_issue", 64'(resp_b), 64'(mon_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    frm_i         = '0;
    issue_ready_i = 1'b1;

    add(32'h00208053, 3'b000, ok(1, 2, 0, 0, 0, 3'b000, 6'b000001, 1,  0, 0), 0); // fadd.s rne
    add(32'h0020F053, 3'b010, ok(1, 2, 0, 0, 0, 3'b010, 6'b000001, 1,  0, 0), 0); // fadd.s dyn
    add(32'h0020F053, 3'b101, ill(1, 2, 0), 0);                                     // dyn reserved
    add(32'h18208043, 3'b000, ok(1, 2, 3, 0, 0, 3'b000, 6'b100000, 4,  0, 0), 1); // fmadd.s
    add(32'h02208053, 3'b000, ok(1, 2, 0, 0, 1, 3'b000, 6'b000001, 1,  0, 0), 1); // fadd.d
    add(32'hA020A2D3, 3'b000, ok(1, 2, 0, 5, 0, 3'b000, 6'b000100, 13, 0, 1), 0); // feq.s
    add(32'h282081D3, 3'b000, ok(1, 2, 0, 3, 0, 3'b000, 6'b000100, 11, 0, 0), 0); // fmin.s
    add(32'hC00110D3, 3'b000, ok(2, 0, 0, 1, 0, 3'b001, 6'b010000, 19, 1, 0), 0); // fcvt.w.s rtz
    add(32'hD011F253, 3'b011, ok(3, 1, 0, 4, 0, 3'b011, 6'b010000, 20, 0, 0), 0); // fcvt.s.wu dyn
    add(32'h18208053, 3'b000, ill(1, 2, 0), 0);                                     // fdiv.s
    add(32'h2020A053, 3'b000, ok(1, 2, 0, 0, 0, 3'b000, 6'b001000, 10, 0, 0), 0); // fsgnjx.s
    add(32'hE00083D3, 3'b000, ok(1, 0, 0, 7, 0, 3'b000, 6'b001000, 17, 0, 0), 0); // fmv.x.w
    add(32'h401100D3, 3'b000, ok(2, 1, 0, 1, 0, 3'b000, 6'b010000, 21, 0, 0), 1); // fcvt.s.d
    add(32'h00208052, 3'b000, ill(1, 2, 0), 0);                                     // bad low bits
    add(32'h04208053, 3'b000, ill(1, 2, 0), 0);                                     // fmt 10

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_valid_a", valid_a, 0);
    check("reset_ready_a", ready_a, 1);
    check("reset_payload_a", 64'(resp_a), 0);
    check("reset_count_a", count_a, 0);
    check("reset_valid_b", valid_b, 0);
    check("reset_count_b", count_b, 0);
    @(posedge clk_i);
    #1;

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      push(i);
      check("count_a", count_a, 64'(exp_cnt_a));
      check("count_b", count_b, 64'(exp_cnt_b));
    end
    instr_valid_i = 1'b0;
    check("stream_no_stall", 64'(stall_cycles), 0);
    check("count_b_saturated", count_b, 3);
    repeat (3) @(posedge clk_i);
    #1;
    check("drain_a", 64'(q_a.size()), 0);
    check("drain_b", 64'(q_b.size()), 0);

    // Backpressure: two accepted, third refused until the consumer drains.
    issue_ready_i = 1'b0;
    push(0);
    push(5);
    instr_valid_i = 1'b1;
    instr_i       = vecs[6].word;
    frm_i         = vecs[6].frm;
    @(negedge clk_i);
    check("full_ready_a", ready_a, 0);
    check("full_valid_a", valid_a, 1);
    @(posedge clk_i);
    #1;
    check("full_still_refused", ready_a, 0);
    issue_ready_i = 1'b1;
    push(6);
    instr_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("bp_drain_a", 64'(q_a.size()), 0);
    check("bp_drain_b", 64'(q_b.size()), 0);

    // Flush with two buffered entries and a new word offered in the same cycle.
    issue_ready_i = 1'b0;
    push(0);
    push(5);
    instr_valid_i = 1'b1;
    instr_i       = vecs[2].word;
    frm_i         = vecs[2].frm;
    flush_i       = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    q_a.delete();
    q_b.delete();
    @(negedge clk_i);
    check("flush_valid_a", valid_a, 0);
    check("flush_ready_a", ready_a, 1);
    check("flush_valid_b", valid_b, 0);
    check("flush_count_a", count_a, 64'(exp_cnt_a));
    check("flush_count_b", count_b, 64'(exp_cnt_b));
    @(posedge clk_i);
    #1 issue_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rereset_count_a", count_a, 0);
    check("rereset_count_b", count_b, 0);
    check("rereset_valid_a", valid_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
